// File: rtl/vec_alu_pkg.sv
// ============================================================================
// vec_alu_pkg: opcodes, FSM encoding and lane geometry for vec_alu_seq.
// Rev 1.0
// ============================================================================
`default_nettype none

package vec_alu_pkg;

  localparam int LANES  = 16;
  localparam int LANE_W = 32;
  localparam int RES_W  = 2 * LANE_W;

  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_SUB     = 2'b01;
  localparam logic [1:0] OP_MUL     = 2'b10;
  localparam logic [1:0] OP_ABSDIFF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vec_alu_lane.sv
// ============================================================================
// vec_alu_lane: combinational single-lane signed ALU, W x W -> 2W result.
// Optional VEC_ALU_OVF_FLAG_EN adds the ovf output. Rev 1.0
// ============================================================================
`default_nettype none

module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [1:0]     op,
  output logic [2*W-1:0] res
`ifdef VEC_ALU_OVF_FLAG_EN
  ,
  output logic           ovf
`endif
);

  logic signed [2*W-1:0] a_x;
  logic signed [2*W-1:0] b_x;
  logic signed [2*W-1:0] diff;

  always_comb begin
    a_x  = {{W{a[W-1]}}, a};
    b_x  = {{W{b[W-1]}}, b};
    diff = a_x - b_x;
    unique case (op)
      OP_ADD:  res = a_x + b_x;
      OP_SUB:  res = diff;
      // Low 2W bits of the 2W x 2W product equal the exact signed W x W product.
      OP_MUL:  res = a_x * b_x;
      default: res = diff[2*W-1] ? -diff : diff;
    endcase
  end

`ifdef VEC_ALU_OVF_FLAG_EN
  assign ovf = !((&res[2*W-1:W-1]) || !(|res[2*W-1:W-1]));
`endif

endmodule

`default_nettype wire

// File: rtl/vec_alu_seq.sv
// ============================================================================
// vec_alu_seq: multi-cycle signed vector ALU, LANES_PER_CYCLE lanes per clock.
// Optional VEC_ALU_OVF_FLAG_EN adds per-lane ovf flags. Rev 1.0
// ============================================================================
`default_nettype none

module vec_alu_seq
  import vec_alu_pkg::*;
#(
  parameter int LANES           = vec_alu_pkg::LANES,
  parameter int LANE_W          = vec_alu_pkg::LANE_W,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  op,
  input  logic [LANES*LANE_W-1:0]     op_a,
  input  logic [LANES*LANE_W-1:0]     op_b,
  output logic                        busy,
  output logic                        done,
  output logic [LANES*2*LANE_W-1:0]   alu_out,
  output logic                        wr_en,
  output logic                        is_alu_result
`ifdef VEC_ALU_OVF_FLAG_EN
  ,
  output logic [LANES-1:0]            ovf
`endif
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LRW   = 2 * LANE_W;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [1:0]                op_q, op_d;
  logic [LANES*LANE_W-1:0]   a_q, a_d;
  logic [LANES*LANE_W-1:0]   b_q, b_d;
  logic [LANES*LRW-1:0]      alu_q, alu_d;

  logic [LANES_PER_CYCLE-1:0][LANE_W-1:0] lane_a;
  logic [LANES_PER_CYCLE-1:0][LANE_W-1:0] lane_b;
  logic [LANES_PER_CYCLE-1:0][LRW-1:0]    lane_res;

`ifdef VEC_ALU_OVF_FLAG_EN
  logic [LANES-1:0]           ovf_q, ovf_d;
  logic [LANES_PER_CYCLE-1:0] lane_ovf;
`endif

  // Slice window: lanes cnt .. cnt+LANES_PER_CYCLE-1 of the latched operands.
  always_comb begin
    for (int k = 0; k < LANES_PER_CYCLE; k++) begin
      lane_a[k] = a_q[(int'(cnt_q) + k)*LANE_W +: LANE_W];
      lane_b[k] = b_q[(int'(cnt_q) + k)*LANE_W +: LANE_W];
    end
  end

  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    vec_alu_lane #(
      .W   (LANE_W)
    ) u_lane (
      .a   (lane_a[g]),
      .b   (lane_b[g]),
      .op  (op_q),
      .res (lane_res[g])
`ifdef VEC_ALU_OVF_FLAG_EN
      ,
      .ovf (lane_ovf[g])
`endif
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
`ifdef VEC_ALU_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          op_d    = op;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < LANES_PER_CYCLE; k++) begin
          alu_d[(int'(cnt_q) + k)*LRW +: LRW] = lane_res[k];
`ifdef VEC_ALU_OVF_FLAG_EN
          ovf_d[int'(cnt_q) + k] = lane_ovf[k];
`endif
        end
        cnt_d = cnt_q + CNT_W'(LANES_PER_CYCLE);
        if (cnt_q == CNT_W'(LANES - LANES_PER_CYCLE)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
`ifdef VEC_ALU_OVF_FLAG_EN
      ovf_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
`ifdef VEC_ALU_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign wr_en         = done;
  assign is_alu_result = done;
  assign alu_out       = alu_q;
`ifdef VEC_ALU_OVF_FLAG_EN
  assign ovf           = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vec_alu_seq.sv
// ============================================================================
// tb_vec_alu_seq: table vectors, hand-written handshake/reset sequences and
// randomized ops against a lane-arithmetic model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_vec_alu_seq;

  localparam int NL  = 16;
  localparam int RUN = 4;   // LANES / LANES_PER_CYCLE

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    op;
  logic [511:0]  op_a, op_b;
  logic          busy, done, wr_en, is_alu_result;
  logic [1023:0] alu_out;
`ifdef VEC_ALU_OVF_FLAG_EN
  logic [15:0]   ovf;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  vec_alu_seq dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .op_a          (op_a),
    .op_b          (op_b),
    .busy          (busy),
    .done          (done),
    .alu_out       (alu_out),
    .wr_en         (wr_en),
    .is_alu_result (is_alu_result)
`ifdef VEC_ALU_OVF_FLAG_EN
    ,
    .ovf           (ovf)
`endif
  );

  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [511:0]  a;
    logic [511:0]  b;
    logic [1023:0] exp;
    logic [15:0]   exp_ovf;
  } vec_t;

  vec_t tbl[8];

  // Reference: each lane as plain 64-bit signed integer arithmetic.
  function automatic logic [1023:0] model_res(input logic [1:0] o,
                                              input logic [511:0] a,
                                              input logic [511:0] b);
    logic [1023:0] r;
    longint x, y, z;
    for (int i = 0; i < NL; i++) begin
      x = longint'($signed(a[32*i +: 32]));
      y = longint'($signed(b[32*i +: 32]));
      case (o)
        2'd0:    z = x + y;
        2'd1:    z = x - y;
        2'd2:    z = x * y;
        default: z = (x > y) ? (x - y) : (y - x);
      endcase
      r[64*i +: 64] = z;
    end
    return r;
  endfunction

  function automatic logic [15:0] model_ovf(input logic [1023:0] r);
    logic [15:0] f;
    longint z;
    for (int i = 0; i < NL; i++) begin
      z = r[64*i +: 64];
      f[i] = (z < -64'sd2147483648) || (z > 64'sd2147483647);
    end
    return f;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [1023:0] exp, input logic [15:0] eovf);
    int bad;
    bad = -1;
    for (int i = 0; i < NL; i++)
      if (bad < 0 && alu_out[64*i +: 64] !== exp[64*i +: 64]) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s lane %0d got=%h exp=%h", nm, bad,
               alu_out[64*bad +: 64], exp[64*bad +: 64]);
    end
`ifdef VEC_ALU_OVF_FLAG_EN
    chk({nm, "_ovf"}, 64'(ovf), 64'(eovf));
`else
    if (eovf === 16'hxxxx) $display("note: unknown ovf expectation in %s", nm);
`endif
  endtask

  // Drive start for one cycle; returns at the first negedge after the capture edge.
  task automatic issue(input logic [1:0] o, input logic [511:0] a, input logic [511:0] b);
    @(negedge clock);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Starts at negedge 1 after capture; done must show at negedge RUN+1.
  task automatic wait_done(input string nm, output bit ok);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (done) lat = k;
      else @(negedge clock);
    end
    ok = (lat != 0);
    chk({nm, "_latency"}, 64'(lat), 64'(RUN + 1));
  endtask

  task automatic run_op(input string nm, input logic [1:0] o,
                        input logic [511:0] a, input logic [511:0] b,
                        input logic [1023:0] exp, input logic [15:0] eovf);
    bit ok;
    issue(o, a, b);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    wait_done(nm, ok);
    if (ok) begin
      check_vec(nm, exp, eovf);
      chk({nm, "_wr_en"}, 64'(wr_en), 64'd1);
      chk({nm, "_is_alu"}, 64'(is_alu_result), 64'd1);
      @(negedge clock);
      chk({nm, "_done_1cyc"}, 64'(done | wr_en), 64'd0);
      chk({nm, "_idle"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic fill(input int idx, input string nm, input logic [1:0] o,
                      input logic [511:0] a, input logic [511:0] b,
                      input logic [1023:0] exp, input logic [15:0] eovf);
    tbl[idx].name = nm; tbl[idx].op = o; tbl[idx].a = a; tbl[idx].b = b;
    tbl[idx].exp = exp; tbl[idx].exp_ovf = eovf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0]  pa, pb, ra, rb;
    logic [1023:0] pe_add, pe_mul, re, prev;
    logic [1:0]    ro;
    bit            ok;
    int            ndone, first;

    reset = 1'b1; start = 1'b0; op = 2'd0; op_a = '0; op_b = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done | wr_en | is_alu_result), 64'd0);
    chk("rst_alu_out", 64'(|alu_out), 64'd0);
`ifdef VEC_ALU_OVF_FLAG_EN
    chk("rst_ovf", 64'(ovf), 64'd0);
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;

    pa = '0; pb = '0;
    pa[31:0] = 32'h10; pa[63:32] = 32'h8000_0000; pa[127:96] = 32'hFFFF_0000;
    pb[31:0] = 32'h2E1; pb[127:96] = 32'hFFFF_0000;
    pe_add = '0;
    pe_add[63:0] = 64'h2F1; pe_add[127:64] = 64'hFFFF_FFFF_8000_0000;
    pe_add[255:192] = 64'hFFFF_FFFF_FFFE_0000;
    pe_mul = '0;
    pe_mul[63:0] = 64'h2E10; pe_mul[255:192] = 64'h0000_0001_0000_0000;

    fill(0, "add_pattern", 2'd0, pa, pb, pe_add, 16'h0000);
    fill(1, "mul_pattern", 2'd2, pa, pb, pe_mul, 16'h0008);
    fill(2, "sub_5_9", 2'd1, {16{32'd5}}, {16{32'd9}}, {16{64'hFFFF_FFFF_FFFF_FFFC}}, 16'h0000);
    fill(3, "absdiff_5_9", 2'd3, {16{32'd5}}, {16{32'd9}}, {16{64'h4}}, 16'h0000);
    fill(4, "mul_minmin", 2'd2, {16{32'h8000_0000}}, {16{32'h8000_0000}},
         {16{64'h4000_0000_0000_0000}}, 16'hFFFF);
    fill(5, "sub_max_min", 2'd1, {16{32'h7FFF_FFFF}}, {16{32'h8000_0000}},
         {16{64'h0000_0000_FFFF_FFFF}}, 16'hFFFF);
    fill(6, "absdiff_min_max", 2'd3, {16{32'h8000_0000}}, {16{32'h7FFF_FFFF}},
         {16{64'h0000_0000_FFFF_FFFF}}, 16'hFFFF);
    fill(7, "add_max_max", 2'd0, {16{32'h7FFF_FFFF}}, {16{32'h7FFF_FFFF}},
         {16{64'h0000_0000_FFFF_FFFE}}, 16'hFFFF);

    for (int t = 0; t < 8; t++)
      run_op(tbl[t].name, tbl[t].op, tbl[t].a, tbl[t].b, tbl[t].exp, tbl[t].exp_ovf);

    // start held during RUN and op_a changed after capture: one done, captured data.
    issue(2'd0, pa, pb);
    ndone = 0; first = 0;
    for (int k = 1; k <= 12; k++) begin
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = k;
          check_vec("busy_ignore_data", pe_add, 16'h0000);
        end
      end
      start = (k <= 4);
      op = 2'd2;
      op_a = {16{$urandom}};
      @(negedge clock);
    end
    start = 1'b0;
    chk("busy_ignore_ndone", 64'(ndone), 64'd1);
    chk("busy_ignore_lat", 64'(first), 64'(RUN + 1));

    // Asynchronous reset mid-RUN.
    issue(2'd2, {16{32'h1234_5678}}, {16{32'h0000_0100}});
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done | wr_en | is_alu_result), 64'd0);
    chk("midrst_alu_out", 64'(|alu_out), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done || busy) ndone++;
      @(negedge clock);
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    run_op("after_rst", tbl[3].op, tbl[3].a, tbl[3].b, tbl[3].exp, tbl[3].exp_ovf);

    // start during DONE is ignored; the following cycle it is accepted.
    issue(2'd0, pa, pb);
    wait_done("done_start_first", ok);
    ra = {16{32'd5}}; rb = {16{32'd9}};
    start = 1'b1; op = 2'd1; op_a = ra; op_b = rb;
    @(negedge clock);
    chk("done_start_ignored", 64'(busy | done), 64'd0);
    @(negedge clock);
    start = 1'b0;
    chk("done_start_accepted", 64'(busy), 64'd1);
    wait_done("done_start_second", ok);
    if (ok) check_vec("done_start_second_data", tbl[2].exp, 16'h0000);
    @(negedge clock);

    // Randomized ops; alu_out from the previous op must not leak into the new result.
    prev = alu_out;
    for (int t = 0; t < 24; t++) begin
      ro = 2'($urandom_range(0, 3));
      for (int i = 0; i < NL; i++) begin
        ra[32*i +: 32] = (($urandom & 7) == 0) ? 32'h8000_0000 : $urandom;
        rb[32*i +: 32] = (($urandom & 7) == 0) ? 32'h7FFF_FFFF : $urandom;
      end
      re = model_res(ro, ra, rb);
      run_op($sformatf("rand%0d_op%0d", t, ro), ro, ra, rb, re, model_ovf(re));
      prev = re;
    end
    if (prev !== alu_out) begin
      checks++;
      failures++;
      $display("FAIL hold_after_done alu_out changed while idle");
    end else begin
      checks++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
